// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
// Execute-side partner of the fetch BTB. Every fetched instruction's
// {pc, predicted next pc} is held in an in-order tracking FIFO. When execute
// resolves the oldest instruction, the entry is popped and the prediction is
// checked. The unit emits a one-cycle BTB update and, on a mispredict, a
// one-cycle redirect together with a flush of all younger entries.
// Optional feature macro: BRU_STATS_EN builds saturating branch and mispredict
// counters. When it is undefined, stat_* are tied to 0.
module branch_resolution_unit #(
   parameter int DEPTH_LOG2  = 3,
   parameter int INSTR_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  fetch_valid,
   input  logic [63:0]           fetch_pc,
   input  logic [63:0]           fetch_pred_pc,
   output logic                  fetch_ready,
   input  logic                  res_valid,
   input  logic                  res_is_branch,
   input  logic                  res_taken,
   input  logic [63:0]           res_target,
   output logic                  upd_en,
   output logic [63:0]           upd_prev_pc,
   output logic [63:0]           upd_branch_pc,
   output logic                  upd_was_taken,
   output logic                  redirect_valid,
   output logic [63:0]           redirect_pc,
   output logic [DEPTH_LOG2:0]   occupancy,
   output logic                  err_underflow,
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts
);

   localparam int                  DEPTH       = 2**DEPTH_LOG2;
   localparam logic [63:0]         LP_STEP     = 64'(INSTR_BYTES);
   localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] LP_OCC_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

   // Tracking storage (data only, never reset)
   logic [63:0]           r_pc_mem   [DEPTH];
   logic [63:0]           r_pred_mem [DEPTH];

   // FIFO control
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_occ;

   // Registered result outputs
   logic                  r_upd_en;
   logic [63:0]           r_upd_prev_pc;
   logic [63:0]           r_upd_branch_pc;
   logic                  r_upd_was_taken;
   logic                  r_redirect_valid;
   logic [63:0]           r_redirect_pc;
   logic                  r_err_underflow;

   // Resolve-side combinational view of the head entry
   logic                  w_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [63:0]           w_head_pc;
   logic [63:0]           w_head_pred;
   logic [63:0]           w_seq_pc;
   logic [63:0]           w_actual_next;
   logic [63:0]           w_pred_next;
   logic                  w_mispredict;

   // Occupancy never exceeds DEPTH, so its MSB alone marks "full".
   assign w_ready       = ~r_occ[DEPTH_LOG2];
   assign w_push        = fetch_valid && w_ready;
   assign w_pop         = res_valid && (r_occ != '0);
   assign w_head_pc     = r_pc_mem[r_rd_ptr];
   assign w_head_pred   = r_pred_mem[r_rd_ptr];
   assign w_seq_pc      = w_head_pc + LP_STEP;
   assign w_actual_next = (res_is_branch && res_taken) ? res_target : w_seq_pc;
   assign w_pred_next   = (w_head_pred != 64'd0) ? w_head_pred : w_seq_pc;
   // A non-branch that hit in the BTB (aliasing) also counts as a mispredict.
   assign w_mispredict  = w_pop && (w_actual_next != w_pred_next);

   // Capture fetch predictions; a push that coincides with a flush is discarded
   always_ff @(posedge clk) begin
      if (w_push && !w_mispredict) begin
         r_pc_mem[r_wr_ptr]   <= fetch_pc;
         r_pred_mem[r_wr_ptr] <= fetch_pred_pc;
      end
   end

   // FIFO pointers and occupancy, cleared by reset or by a mispredict flush
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (w_mispredict) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + LP_OCC_ONE;
            2'b01:   r_occ <= r_occ - LP_OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // One-cycle BTB update, redirect pulse and sticky underflow flag
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_upd_en         <= 1'b0;
         r_upd_prev_pc    <= 64'd0;
         r_upd_branch_pc  <= 64'd0;
         r_upd_was_taken  <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 64'd0;
         r_err_underflow  <= 1'b0;
      end else begin
         r_upd_en         <= 1'b0;
         r_upd_prev_pc    <= 64'd0;
         r_upd_branch_pc  <= 64'd0;
         r_upd_was_taken  <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 64'd0;
         if (w_pop && res_is_branch) begin
            r_upd_en        <= 1'b1;
            r_upd_prev_pc   <= w_head_pc;
            r_upd_branch_pc <= res_target;
            r_upd_was_taken <= res_taken;
         end
         if (w_mispredict) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_actual_next;
         end
         if (res_valid && (r_occ == '0)) begin
            r_err_underflow <= 1'b1;
         end
      end
   end

`ifdef BRU_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Saturating resolution statistics
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else begin
         if (w_pop && res_is_branch && (r_stat_branches != 32'hFFFF_FFFF)) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`else
   assign stat_branches    = 32'd0;
   assign stat_mispredicts = 32'd0;
`endif

   assign fetch_ready    = w_ready;
   assign occupancy      = r_occ;
   assign upd_en         = r_upd_en;
   assign upd_prev_pc    = r_upd_prev_pc;
   assign upd_branch_pc  = r_upd_branch_pc;
   assign upd_was_taken  = r_upd_was_taken;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign err_underflow  = r_err_underflow;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed testbench for branch_resolution_unit. Honours BRU_STATS_EN for the
// expected statistics values.
module tb_branch_resolution_unit;

   logic        clk;
   logic        arst_n;
   logic        fetch_valid;
   logic [63:0] fetch_pc;
   logic [63:0] fetch_pred_pc;
   logic        fetch_ready;
   logic        res_valid;
   logic        res_is_branch;
   logic        res_taken;
   logic [63:0] res_target;
   logic        upd_en;
   logic [63:0] upd_prev_pc;
   logic [63:0] upd_branch_pc;
   logic        upd_was_taken;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [3:0]  occupancy;
   logic        err_underflow;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] model_q[$];
   logic [63:0] exp_head;

   branch_resolution_unit #(.DEPTH_LOG2(3), .INSTR_BYTES(4)) dut (
      .clk(clk), .arst_n(arst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred_pc(fetch_pred_pc),
      .fetch_ready(fetch_ready),
      .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
      .res_target(res_target),
      .upd_en(upd_en), .upd_prev_pc(upd_prev_pc), .upd_branch_pc(upd_branch_pc),
      .upd_was_taken(upd_was_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .occupancy(occupancy), .err_underflow(err_underflow),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle();
      fetch_valid   = 1'b0;
      fetch_pc      = 64'd0;
      fetch_pred_pc = 64'd0;
      res_valid     = 1'b0;
      res_is_branch = 1'b0;
      res_taken     = 1'b0;
      res_target    = 64'd0;
   endtask

   task automatic push(input logic [63:0] pc, input logic [63:0] pred);
      fetch_valid   = 1'b1;
      fetch_pc      = pc;
      fetch_pred_pc = pred;
   endtask

   task automatic resolve(input logic br, input logic tk, input logic [63:0] tgt);
      res_valid     = 1'b1;
      res_is_branch = br;
      res_taken     = tk;
      res_target    = tgt;
   endtask

   task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BRU_STATS_EN
      chk({tag, "_branches"}, 64'(stat_branches), 64'(br));
      chk({tag, "_mispredicts"}, 64'(stat_mispredicts), 64'(mp));
`else
      chk({tag, "_branches"}, 64'(stat_branches), 64'd0);
      chk({tag, "_mispredicts"}, 64'(stat_mispredicts), 64'd0);
      if (br == mp) n_checks += 0;
`endif
   endtask

   initial begin
      idle();
      arst_n = 1'b0;
      tick();
      tick();
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_ready", 64'(fetch_ready), 64'd1);
      chk("rst_upd_en", 64'(upd_en), 64'd0);
      chk("rst_redirect", 64'(redirect_valid), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      chk_stats("rst", 32'd0, 32'd0);
      arst_n = 1'b1;

      // Two sequential non-branches
      push(64'h100, 64'd0); tick();
      chk("s1_occ1", 64'(occupancy), 64'd1);
      push(64'h104, 64'd0); tick();
      chk("s1_occ2", 64'(occupancy), 64'd2);
      idle(); resolve(1'b0, 1'b0, 64'd0); tick();
      chk("s1_upd_en_a", 64'(upd_en), 64'd0);
      chk("s1_redir_a", 64'(redirect_valid), 64'd0);
      chk("s1_occ_a", 64'(occupancy), 64'd1);
      tick();
      chk("s1_upd_en_b", 64'(upd_en), 64'd0);
      chk("s1_redir_b", 64'(redirect_valid), 64'd0);
      chk("s1_occ_b", 64'(occupancy), 64'd0);

      // Correctly predicted taken branch
      idle(); push(64'h200, 64'h400); tick();
      idle(); resolve(1'b1, 1'b1, 64'h400); tick();
      chk("s2_upd_en", 64'(upd_en), 64'd1);
      chk("s2_prev_pc", upd_prev_pc, 64'h200);
      chk("s2_branch_pc", upd_branch_pc, 64'h400);
      chk("s2_taken", 64'(upd_was_taken), 64'd1);
      chk("s2_redir", 64'(redirect_valid), 64'd0);
      chk("s2_occ", 64'(occupancy), 64'd0);
      idle(); tick();
      chk("s2_upd_pulse", 64'(upd_en), 64'd0);

      // Taken branch predicted fall-through, with younger entries and a same-cycle push
      push(64'h300, 64'd0); tick();
      push(64'h304, 64'd0); tick();
      push(64'h308, 64'd0); tick();
      chk("s3_occ3", 64'(occupancy), 64'd3);
      push(64'h30C, 64'd0); resolve(1'b1, 1'b1, 64'h800); tick();
      chk("s3_redir", 64'(redirect_valid), 64'd1);
      chk("s3_redir_pc", redirect_pc, 64'h800);
      chk("s3_occ_flush", 64'(occupancy), 64'd0);
      chk("s3_ready", 64'(fetch_ready), 64'd1);
      chk("s3_upd_en", 64'(upd_en), 64'd1);
      chk("s3_prev_pc", upd_prev_pc, 64'h300);
      idle(); tick();
      chk("s3_redir_pulse", 64'(redirect_valid), 64'd0);
      chk("s3_occ_after", 64'(occupancy), 64'd0);
      chk("s3_redir_pc_zero", redirect_pc, 64'd0);

      // Predicted taken, actually not taken
      push(64'h500, 64'h900); tick();
      idle(); resolve(1'b1, 1'b0, 64'h900); tick();
      chk("s4_redir", 64'(redirect_valid), 64'd1);
      chk("s4_redir_pc", redirect_pc, 64'h504);
      chk("s4_upd_en", 64'(upd_en), 64'd1);
      chk("s4_taken", 64'(upd_was_taken), 64'd0);
      chk("s4_branch_pc", upd_branch_pc, 64'h900);
      idle();

      // Non-branch aliased onto a BTB hit
      push(64'h600, 64'h700); tick();
      idle(); resolve(1'b0, 1'b0, 64'd0); tick();
      chk("s4b_redir", 64'(redirect_valid), 64'd1);
      chk("s4b_redir_pc", redirect_pc, 64'h604);
      chk("s4b_upd_en", 64'(upd_en), 64'd0);
      idle();
      chk_stats("s4", 32'd3, 32'd3);

      // Fill to full, try a ninth push
      for (int i = 0; i < 8; i++) begin
         push(64'h1000 + 64'(4 * i), 64'd0);
         model_q.push_back(64'h1000 + 64'(4 * i));
         tick();
      end
      chk("s5_occ_full", 64'(occupancy), 64'd8);
      chk("s5_ready_full", 64'(fetch_ready), 64'd0);
      push(64'hDEAD0, 64'd0); tick();
      chk("s5_occ_drop", 64'(occupancy), 64'd8);
      idle();

      // Single pop to open a slot
      exp_head = model_q.pop_front();
      resolve(1'b1, 1'b1, exp_head + 64'd4); tick();
      chk("s5_first_prev", upd_prev_pc, exp_head);
      chk("s5_first_occ", 64'(occupancy), 64'd7);

      // Concurrent push and pop across pointer wrap
      for (int k = 0; k < 20; k++) begin
         exp_head = model_q.pop_front();
         model_q.push_back(64'h2000 + 64'(4 * k));
         push(64'h2000 + 64'(4 * k), 64'd0);
         resolve(1'b1, 1'b1, exp_head + 64'd4);
         tick();
         chk("s5_wrap_prev", upd_prev_pc, exp_head);
         chk("s5_wrap_redir", 64'(redirect_valid), 64'd0);
         chk("s5_wrap_occ", 64'(occupancy), 64'd7);
      end
      idle();

      // Drain in order
      for (int k = 0; k < 7; k++) begin
         exp_head = model_q.pop_front();
         resolve(1'b1, 1'b1, exp_head + 64'd4);
         tick();
         chk("s5_drain_prev", upd_prev_pc, exp_head);
         chk("s5_drain_redir", 64'(redirect_valid), 64'd0);
      end
      idle();
      chk("s5_drain_occ", 64'(occupancy), 64'd0);

      // Underflow
      resolve(1'b0, 1'b0, 64'd0); tick();
      chk("s6_err", 64'(err_underflow), 64'd1);
      chk("s6_upd_en", 64'(upd_en), 64'd0);
      chk("s6_redir", 64'(redirect_valid), 64'd0);
      chk("s6_occ", 64'(occupancy), 64'd0);
      idle(); tick(); tick();
      chk("s6_err_sticky", 64'(err_underflow), 64'd1);
      chk_stats("s6", 32'd31, 32'd3);

      // Reset mid-stream
      push(64'h3000, 64'd0); tick();
      push(64'h3004, 64'd0); tick();
      chk("s7_occ_pre", 64'(occupancy), 64'd2);
      arst_n = 1'b0;
      push(64'h3008, 64'd0); resolve(1'b1, 1'b1, 64'hF00); tick();
      chk("s7_occ", 64'(occupancy), 64'd0);
      chk("s7_ready", 64'(fetch_ready), 64'd1);
      chk("s7_upd_en", 64'(upd_en), 64'd0);
      chk("s7_redir", 64'(redirect_valid), 64'd0);
      chk("s7_err", 64'(err_underflow), 64'd0);
      chk_stats("s7", 32'd0, 32'd0);
      idle();
      arst_n = 1'b1;

      // Old entries must be gone after reset
      push(64'h4000, 64'd0); tick();
      idle(); resolve(1'b1, 1'b1, 64'h4004); tick();
      chk("s8_prev_pc", upd_prev_pc, 64'h4000);
      chk("s8_redir", 64'(redirect_valid), 64'd0);
      idle(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Execute-side counterpart of the fetch-stage branch target buffer. Records each fetch-stage prediction (PC, predicted target) in an in-order tracking FIFO. When execute resolves the instruction, it pops the matching entry, compares the actual next PC with the predicted next PC, and produces:
- the BTB update triplet;
- a pipeline redirect/flush on misprediction.

## Interface
Parameters:
- DEPTH_LOG2, 3, log2 of tracking FIFO depth (depth = 2**DEPTH_LOG2 in-flight instructions)
- INSTR_BYTES, 4, PC increment for sequential fall-through

Ports:
- clk  in  1  clock; all logic on rising edge
- arst_n  in  1  reset, synchronous, active-low
- fetch_valid  in  1  fetch issues an instruction this cycle
- fetch_pc  in  64  PC of issued instruction
- fetch_pred_pc  in  64  BTB prediction for fetch_pc; 0 = no prediction (fall-through)
- fetch_ready  out  1  FIFO can accept an entry (= not full)
- res_valid  in  1  execute resolves oldest in-flight instruction
- res_is_branch  in  1  resolved instruction is a control-transfer
- res_taken  in  1  branch taken (ignored unless res_is_branch)
- res_target  in  64  resolved branch target
- upd_en  out  1  BTB update strobe (BTB en)
- upd_prev_pc  out  64  PC of resolved branch
- upd_branch_pc  out  64  resolved target
- upd_was_taken  out  1  taken outcome for BTB
- redirect_valid  out  1  mispredict: flush younger, refetch
- redirect_pc  out  64  correct next PC
- occupancy  out  DEPTH_LOG2+1  entries in FIFO
- err_underflow  out  1  sticky: res_valid while empty
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Push: fetch_valid && fetch_ready stores {fetch_pc, fetch_pred_pc} at write pointer. A push while full is dropped; fetch must hold.
- Pop: res_valid with occupancy>0 pops the head entry {h_pc, h_pred}.
- actual_next = (res_is_branch && res_taken) ? res_target : h_pc + INSTR_BYTES. Use 64-bit wrap arithmetic.
- pred_next = (h_pred != 0) ? h_pred : h_pc + INSTR_BYTES.
- mispredict = actual_next != pred_next. This includes a non-branch whose PC aliased to a BTB hit.
- upd_en = res_is_branch for the popped entry. upd_prev_pc = h_pc, upd_branch_pc = res_target, upd_was_taken = res_taken. Non-branches never update.
- Mispredict: redirect_valid=1 and redirect_pc=actual_next. The FIFO is flushed: pointers reset, occupancy→0. A push in the same cycle is discarded.
- res_valid with occupancy==0: no pop, no outputs, err_underflow set. It is cleared only by reset.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Full/empty are distinguished by occupancy.

## Timing
- Reset (arst_n=0 at edge): FIFO empty, occupancy=0, fetch_ready=1. All upd_* / redirect_* = 0, err_underflow=0, stats=0. Reset mid-operation discards all in-flight entries.
- upd_* and redirect_* are registered, valid for exactly one cycle, the cycle after the resolving edge. They return to 0 otherwise.
- Flush takes effect at the same edge that registers redirect_valid. fetch_ready=1 in the redirect cycle.
- Simultaneous push and pop without mispredict: occupancy unchanged. This is allowed at full only if fetch_ready was 1, so there is no bypass: fetch_ready = occupancy < depth.
- Push-to-earliest-pop: 1 cycle (an entry pushed at edge N is poppable at edge N+1).

## Configuration
- BRU_STATS_EN defined: stat_branches increments on each popped branch. stat_mispredicts increments on each mispredict. Both are 32-bit, saturate at 0xFFFF_FFFF and are reset to 0.
- BRU_STATS_EN undefined: counters not built; stat_* tied to 0.

## Test plan
- Push pc=0x100 pred=0 and pc=0x104 pred=0. Resolve both as non-branch → no upd_en, no redirect, occupancy 2→0.
- Push pc=0x200 pred=0x400. Resolve branch taken target=0x400 → upd_en=1, upd_prev_pc=0x200, upd_branch_pc=0x400, upd_was_taken=1, redirect_valid=0.
- Push pc=0x300 pred=0 plus two younger entries. Resolve branch taken target=0x800 → redirect_valid=1, redirect_pc=0x800, occupancy=0 next cycle, a same-cycle push dropped.
- Push pc=0x500 pred=0x900. Resolve branch not taken → redirect_pc=0x504, upd_was_taken=0, upd_en=1.
- Fill to depth 8 → fetch_ready=0, 9th push ignored. Pop and push together for 20 cycles → pointers wrap, FIFO order preserved.
- res_valid with empty FIFO → err_underflow=1 sticky. Assert arst_n=0 mid-stream → all outputs and occupancy 0 next cycle. With BRU_STATS_EN, counters match scenario totals.
